// File: rtl/axis_loopback_tester.sv
// AXI-Stream loopback tester: sends a seed+k pattern frame on m01,
// receives it back on s01, checks each beat and reports the result.
//
// Ports:
//   axis_aclk, axis_aresetn        clock, async active-low reset
//   start, frame_len, seed         test request (taken only in IDLE)
//   m01_axis_*                     pattern transmit master
//   s01_axis_*                     echo receive slave
//   busy, done, pass, err_count,   status; pass/err_count/timeout hold
//   timeout                        until the next accepted start
module axis_loopback_tester #(
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH       = 11
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    frame_len,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [LEN_WIDTH-1:0]    err_count,
  output logic                    timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RECV,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [LEN_WIDTH-1:0]    beat_q, beat_d;
  logic [TO_WIDTH-1:0]     to_q, to_d;
  logic [LEN_WIDTH-1:0]    err_q, err_d;
  logic                    pass_q, pass_d;
  logic                    tmo_q, tmo_d;
  logic                    done_q, done_d;

  logic                    in_send;
  logic                    in_recv;
  logic                    m_hs;
  logic                    s_hs;
  logic                    last_k;
  logic                    to_hit;
  logic [DATA_WIDTH-1:0]   exp_data;
  logic                    bad;

  assign in_send  = (state_q == S_SEND);
  assign in_recv  = (state_q == S_RECV);
  assign m_hs     = in_send && m01_axis_tready;
  assign s_hs     = in_recv && s01_axis_tvalid;
  assign last_k   = (beat_q == len_q - LEN_WIDTH'(1));
  assign to_hit   = (to_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign exp_data = seed_q + DATA_WIDTH'(beat_q);

  // One bad flag per beat, however many checks trip.
  assign bad = (s01_axis_tdata != exp_data)
            || (s01_axis_tstrb != '1)
            || (s01_axis_tlast != last_k);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    seed_d  = seed_q;
    beat_d  = beat_q;
    to_d    = to_q;
    err_d   = err_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = frame_len;
          seed_d  = seed;
          beat_d  = '0;
          to_d    = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = (frame_len == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (m_hs) begin
          to_d = '0;
          if (last_k) begin
            beat_d  = '0;
            state_d = S_RECV;
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end else if (to_hit) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_d = to_q + TO_WIDTH'(1);
        end
      end
      S_RECV: begin
        if (s_hs) begin
          to_d = '0;
          if (bad && (err_q != '1)) begin
            err_d = err_q + LEN_WIDTH'(1);
          end
          // Frame length, not tlast, ends reception.
          if (last_k) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end else if (to_hit) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_d = to_q + TO_WIDTH'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0) && !tmo_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      seed_q  <= '0;
      beat_q  <= '0;
      to_q    <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end

  // Data/strobe are forced low outside SEND so reset and idle show zeros.
  assign m01_axis_tvalid = in_send;
  assign m01_axis_tdata  = in_send ? exp_data : '0;
  assign m01_axis_tstrb  = {(DATA_WIDTH/8){in_send}};
  assign m01_axis_tlast  = in_send && last_k;
  assign s01_axis_tready = in_recv;
  assign busy            = in_send || in_recv;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign timeout         = tmo_q;

endmodule
